// File: rtl/clock_divider_multi_pkg.sv
// clkdiv_pkg: shared constants for the multi-channel clock divider
package clkdiv_pkg;
  localparam int CLKDIV_WIDTH = 32;
  localparam int CLKDIV_MIN_DIV = 2;
  localparam logic CLKDIV_IDLE = 1'b0;
endpackage

// File: rtl/clock_divider_multi_if.sv
// clock_divider_multi_if: per-channel control and divided-clock outputs
import clkdiv_pkg::*;

interface clock_divider_multi_if #(
  parameter int CHANNELS = 4,
  parameter int WIDTH = CLKDIV_WIDTH
);
  logic [CHANNELS-1:0] en;
  logic [CHANNELS*WIDTH-1:0] div;
  logic [CHANNELS*WIDTH-1:0] high;
  logic [CHANNELS-1:0] outclk;
  logic [CHANNELS-1:0] tick;
  logic [CHANNELS-1:0] active;
  modport master(output en, div, high, input outclk, tick, active);
  modport slave(input en, div, high, output outclk, tick, active);
endinterface

// File: rtl/clock_divider_multi_channel.sv
// clkdiv_channel: one divider with shadow-loaded period and high length
import clkdiv_pkg::*;

module clkdiv_channel #(
  parameter int WIDTH = CLKDIV_WIDTH
) (
  input  logic             refclk,
  input  logic             resetn,
  input  logic             en,
  input  logic [WIDTH-1:0] div,
  input  logic [WIDTH-1:0] high,
  output logic             outclk,
  output logic             tick,
  output logic             active
);
  logic [WIDTH-1:0] cnt, ns, hs;
  logic run, ok, term, stop, load;
  assign ok = div >= WIDTH'(CLKDIV_MIN_DIV);
  assign term = cnt == ns - WIDTH'(1);
  assign stop = !en || ((!run || term) && !ok);
  assign load = !run || term;
  assign active = run;
  // idle on disable or bad divisor, reload at start/period end, otherwise count
  always_ff @(posedge refclk or negedge resetn)
    if (!resetn) begin
      cnt <= '0;
      ns <= '0;
      hs <= '0;
      run <= 1'b0;
      outclk <= CLKDIV_IDLE;
      tick <= 1'b0;
    end else if (stop) begin
      cnt <= '0;
      run <= 1'b0;
      outclk <= CLKDIV_IDLE;
      tick <= 1'b0;
    end else if (load) begin
      ns <= div;
      hs <= high;
      cnt <= '0;
      run <= 1'b1;
      tick <= 1'b1;
      outclk <= high != '0;
    end else begin
      cnt <= cnt + WIDTH'(1);
      tick <= 1'b0;
      outclk <= (cnt + WIDTH'(1)) < hs;
    end
endmodule

// File: rtl/clock_divider_multi.sv
// clock_divider_multi: CHANNELS independent programmable clock dividers
import clkdiv_pkg::*;

module clock_divider_multi #(
  parameter int CHANNELS = 4,
  parameter int WIDTH = CLKDIV_WIDTH
) (
  input logic refclk,
  input logic resetn,
  clock_divider_multi_if.slave bus
);
  for (genvar g = 0; g < CHANNELS; g++) begin : ch
    clkdiv_channel #(.WIDTH(WIDTH)) u_ch (
      .refclk(refclk),
      .resetn(resetn),
      .en(bus.en[g]),
      .div(bus.div[g*WIDTH +: WIDTH]),
      .high(bus.high[g*WIDTH +: WIDTH]),
      .outclk(bus.outclk[g]),
      .tick(bus.tick[g]),
      .active(bus.active[g])
    );
  end
endmodule

// File: tb/tb_clock_divider_multi.sv
// tb_clock_divider_multi: directed and random checks against a period/phase model
module tb_clock_divider_multi;
  import clkdiv_pkg::*;
  localparam int C = 4;
  localparam int W = 8;
  logic refclk = 1'b0;
  logic resetn = 1'b0;
  int checks = 0;
  int errors = 0;
  bit mr[C];
  int mp[C], mn[C], mh[C];
  logic [31:0] ho[C], ht[C];

  clock_divider_multi_if #(.CHANNELS(C), .WIDTH(W)) bus();
  clock_divider_multi #(.CHANNELS(C), .WIDTH(W)) dut (.refclk(refclk), .resetn(resetn), .bus(bus));

  always #5 refclk = ~refclk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chkv(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_ch(input int i, input int n, input int h, input bit e);
    bus.en[i] = e;
    bus.div[i*W +: W] = W'(n);
    bus.high[i*W +: W] = W'(h);
  endtask

  task automatic model_reset();
    for (int i = 0; i < C; i++) begin
      mr[i] = 0;
      mp[i] = 0;
    end
  endtask

  // each channel is "in a period of mn cycles at phase mp", high for the first mh phases
  task automatic model_edge();
    for (int i = 0; i < C; i++) begin
      int n, h;
      n = int'(bus.div[i*W +: W]);
      h = int'(bus.high[i*W +: W]);
      if (!bus.en[i]) mr[i] = 0;
      else if (!mr[i] || mp[i] == mn[i] - 1) begin
        mr[i] = n >= 2;
        mp[i] = 0;
        if (n >= 2) begin
          mn[i] = n;
          mh[i] = h;
        end
      end else mp[i]++;
    end
  endtask

  task automatic compare_all(input string tag);
    for (int i = 0; i < C; i++) begin
      chk($sformatf("%s ch%0d outclk", tag, i), bus.outclk[i], mr[i] && mp[i] < mh[i]);
      chk($sformatf("%s ch%0d tick", tag, i), bus.tick[i], mr[i] && mp[i] == 0);
      chk($sformatf("%s ch%0d active", tag, i), bus.active[i], mr[i]);
    end
  endtask

  task automatic cycle(input string tag);
    @(posedge refclk);
    if (resetn) model_edge();
    @(negedge refclk);
    compare_all(tag);
    for (int i = 0; i < C; i++) begin
      ho[i] = {ho[i][30:0], bus.outclk[i]};
      ht[i] = {ht[i][30:0], bus.tick[i]};
    end
  endtask

  task automatic run(input int n, input string tag);
    for (int k = 0; k < n; k++) cycle(tag);
  endtask

  task automatic async_reset(input string tag);
    #2 resetn = 1'b0;
    #1 model_reset();
    compare_all(tag);
    @(negedge refclk);
    resetn = 1'b1;
  endtask

  initial begin
    bus.en = '0;
    bus.div = '0;
    bus.high = '0;
    model_reset();
    for (int i = 0; i < C; i++) begin
      mn[i] = 0;
      mh[i] = 0;
    end
    #1 compare_all("reset");
    @(negedge refclk);
    @(negedge refclk);
    resetn = 1'b1;
    run(2, "idle");

    set_ch(0, 4, 2, 1);
    set_ch(1, 5, 2, 1);
    for (int i = 0; i < C; i++) begin ho[i] = 0; ht[i] = 0; end
    run(8, "basic");
    chkv("ch0 pattern 1100", {24'h0, ho[0][7:0]}, 32'b11001100);
    chkv("ch0 ticks", {24'h0, ht[0][7:0]}, 32'b10001000);
    chkv("ch1 pattern 11000", {24'h0, ho[1][7:0]}, 32'b11000110);
    chkv("ch1 ticks", {24'h0, ht[1][7:0]}, 32'b10000100);
    run(2, "basic");

    set_ch(0, 6, 3, 1);
    set_ch(1, 5, 0, 1);
    ho[0] = 0;
    run(14, "reprogram");
    chkv("ch0 switch 1100->111000", {18'h0, ho[0][13:0]}, 32'b00111000111000);
    set_ch(1, 5, 7, 1);
    run(10, "h_over_n");

    set_ch(2, 8, 4, 1);
    run(4, "disable");
    set_ch(2, 8, 4, 0);
    run(1, "disable");
    chk("ch2 off outclk", bus.outclk[2], 1'b0);
    chk("ch2 off tick", bus.tick[2], 1'b0);
    chk("ch2 off active", bus.active[2], 1'b0);
    set_ch(2, 8, 4, 1);
    run(1, "reenable");
    chk("ch2 restart tick", bus.tick[2], 1'b1);
    chk("ch2 restart outclk", bus.outclk[2], 1'b1);

    set_ch(3, 1, 1, 1);
    run(3, "n1");
    chk("ch3 n1 active", bus.active[3], 1'b0);
    set_ch(3, 0, 1, 1);
    run(3, "n0");
    chk("ch3 n0 outclk", bus.outclk[3], 1'b0);
    set_ch(3, 3, 1, 1);
    run(1, "n3");
    chk("ch3 n3 tick", bus.tick[3], 1'b1);
    chk("ch3 n3 active", bus.active[3], 1'b1);
    run(2, "n3");

    async_reset("async");
    for (int i = 0; i < C; i++) chk($sformatf("ch%0d held low", i), bus.outclk[i], 1'b0);
    run(1, "release");
    for (int i = 0; i < C; i++) chk($sformatf("ch%0d restart tick", i), bus.tick[i], 1'b1);
    run(5, "release");

    for (int k = 0; k < 600; k++) begin
      for (int i = 0; i < C; i++)
        if ($urandom_range(0, 7) == 0)
          set_ch(i, int'($urandom_range(0, 9)), int'($urandom_range(0, 10)), $urandom_range(0, 5) != 0);
      if ($urandom_range(0, 99) == 0) async_reset("rand_reset");
      cycle("random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/clock_divider_multi.md
Name: clock_divider_multi

Overview:
- Multi-channel programmable clock generator driven from one reference clock.
- Each channel produces a divided clock with:
  - a runtime integer period N, in refclk cycles,
  - a runtime high-phase length H, giving arbitrary duty cycle and exact odd division,
  - a one-cycle tick strobe at the start of every period.
- Divisor and duty values are shadow-loaded only at period boundaries, so reprogramming never glitches the output.
- Used wherever the design needs several slow strobes or clocks derived from refclk: display scan, debounce, game timing.

Parameters:
- CHANNELS, 4: number of independent divider channels.
- WIDTH, 32: width of each divisor, high-length and internal counter.

Ports:
- refclk  input  1  reference clock; all logic is on its rising edge.
- resetn  input  1  asynchronous, active-low reset.
- en  input  CHANNELS  per-channel enable. Bit i gates channel i.
- div  input  CHANNELS*WIDTH  period N per channel. Channel i occupies bits [i*WIDTH +: WIDTH].
- high  input  CHANNELS*WIDTH  high-phase length H per channel, same packing as div.
- outclk  output  CHANNELS  divided clock per channel; registered, glitch-free.
- tick  output  CHANNELS  one-refclk-cycle pulse on the first cycle of each period.
- active  output  CHANNELS  channel running with a valid latched N (N>=2).

Behaviour:
- Reset:
  - resetn low asynchronously clears all counters, shadow N/H registers, outclk, tick and active to 0.
  - Release is synchronous in effect: the first edge with resetn high is treated as a normal cycle.
- Per channel, state is:
  - cnt (WIDTH bits),
  - shadow registers Ns and Hs,
  - run flag, exported as active.
- Idle (run=0): outclk=0, tick=0, cnt=0.
- Start: at a rising edge where en=1 and run=0:
  - If N>=2: Ns<=N, Hs<=H, cnt<=0, run<=1, tick<=1, outclk<=(H>0).
  - If N<2: the channel stays idle and all outputs stay 0. It retries on every subsequent edge.
- Running, when cnt != Ns-1:
  - cnt<=cnt+1, tick<=0, outclk<=((cnt+1) < Hs).
- Running, at the terminal count (cnt == Ns-1, last cycle of the period): sample div/high.
  - If new N>=2: Ns<=N, Hs<=H, cnt<=0, tick<=1, outclk<=(H>0).
  - If new N<2: run<=0 and the channel goes idle next cycle. The current period has completed cleanly.
- Resulting waveform:
  - Period is exactly Ns refclk cycles.
  - outclk is high for min(Hs,Ns) cycles, then low for the remainder.
  - Hs=0 gives constant low with ticks still produced.
  - Hs>=Ns gives constant high while running.
  - Odd Ns is exact, e.g. N=5 with H=2 gives 2 high / 3 low.
- Mid-period changes: changes to div/high outside the terminal-count cycle have no effect until that cycle.
- Disable: at any edge with en=0 while running, the channel synchronously goes idle on that edge:
  - cnt<=0, outclk<=0, tick<=0, run<=0.
  - An immediate stop with a truncated period is acceptable and required.
- Simultaneous events:
  - en=0 at the terminal count: disable wins.
  - en rising on the same edge as a reset release: that edge starts the channel.
- Reset mid-period: outputs drop asynchronously. After release, a channel with en=1 restarts a fresh period with tick=1 on the first edge.
- Arithmetic:
  - Compare cnt against Ns-1 using WIDTH bits. Ns>=2 guarantees no underflow.
  - The counter never wraps, because cnt is bounded by Ns-1 < 2^WIDTH.
- Independence: channels share only refclk and resetn. There is no cross-channel phase relation except that channels started on the same edge with equal N/H stay in phase.

Decomposition:
- Package clkdiv_pkg holds:
  - CLKDIV_WIDTH default 32,
  - CLKDIV_MIN_DIV = 2,
  - a helper constant for the idle output value (0).
- Sub-module clkdiv_channel (one refclk/resetn/en/div/high -> outclk/tick/active). The top generates CHANNELS instances and handles slicing of the packed buses.

Test Plan:
- N=4, H=2, en held high on ch0 -> outclk pattern 1100 repeating from the first edge after en; tick high on cycles 0,4,8; active=1.
- N=5, H=2 on ch1 -> pattern 11000, period 5. N=5, H=0 -> outclk constant 0 with tick every 5 cycles. N=5, H=7 -> outclk constant 1.
- Running at N=4, H=2, change to N=6, H=3 at cycle 1 of a period -> the current period finishes as 1100, then 111000 follows; no glitch or short pulse at the switch.
- Running N=8; drop en at cycle 3 -> outclk=0, tick=0, active=0 on the next edge. Reassert en -> new period with tick=1 and outclk=1 on the first edge.
- N=1 or N=0 with en=1 -> outclk, tick and active all stay 0. Change to N=3 while en is held -> start on the next edge.
- Assert resetn=0 asynchronously mid-period on all 4 channels with differing N -> all outputs are 0 immediately. After release, each restarts at cnt=0 with tick=1.
